// File: rtl/lvds_multilane_aligner.sv
// Per-lane bitslip word alignment followed by multi-lane deskew on sync_word.
// Define ALIGN_STATS_EN to add the slip_count and lane_skew status outputs.
module lvds_multilane_aligner #(
  parameter int NUM_LANES      = 4,
  parameter int DATA_WIDTH     = 10,
  parameter int MATCH_COUNT    = 4,
  parameter int SLIP_WAIT      = 3,
  parameter int MAX_SKEW       = 7,
  parameter int SEARCH_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            align_en,
  input  logic [NUM_LANES-1:0]            lane_ready,
  input  logic [DATA_WIDTH-1:0]           pattern,
  input  logic [DATA_WIDTH-1:0]           sync_word,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  output logic [NUM_LANES-1:0]            bitslip,
  output logic [NUM_LANES-1:0]            lane_locked,
  output logic                            align_done,
  output logic                            align_fail,
  output logic [NUM_LANES*DATA_WIDTH-1:0] tdata,
  output logic                            tvalid
`ifdef ALIGN_STATS_EN
  ,
  output logic [NUM_LANES*4-1:0]          slip_count,
  output logic [NUM_LANES*5-1:0]          lane_skew
`endif
);

  localparam int DLW   = $clog2(MAX_SKEW+1) + 1;
  localparam int TW    = $clog2(SEARCH_TIMEOUT+1);
  localparam int CW    = (TW > DLW) ? TW : DLW;
  localparam int DEPTH = MAX_SKEW + 1;

  localparam logic [3:0]    MC_LAST  = 4'(MATCH_COUNT - 1);
  localparam logic [3:0]    SW_LAST  = 4'(SLIP_WAIT - 1);
  localparam logic [3:0]    SLIP_MAX = 4'(DATA_WIDTH);
  localparam logic [CW-1:0] TO_CNT   = CW'(SEARCH_TIMEOUT);
  localparam logic [CW-1:0] SKEW_LIM = CW'(MAX_SKEW);

  typedef enum logic [2:0] {
    L_IDLE, L_CHECK, L_SLIP, L_WAIT, L_LOCK, L_FAIL
  } lane_st_t;

  typedef enum logic [1:0] {
    D_IDLE, D_SEARCH, D_DONE, D_FAIL
  } desk_st_t;

  lane_st_t l_st [NUM_LANES];
  lane_st_t l_nxt [NUM_LANES];
  logic [3:0] slip_cnt [NUM_LANES];
  logic [3:0] slip_nxt [NUM_LANES];
  logic [3:0] match_cnt [NUM_LANES];
  logic [3:0] match_nxt [NUM_LANES];
  logic [3:0] wait_cnt [NUM_LANES];
  logic [3:0] wait_nxt [NUM_LANES];

  logic [NUM_LANES-1:0] pat_hit;
  logic [NUM_LANES-1:0] sync_hit;
  logic [NUM_LANES-1:0] lane_fail;

  desk_st_t d_st, d_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] arrival [NUM_LANES];
  logic [NUM_LANES-1:0] cap;
  logic [DLW-1:0] delay [NUM_LANES];
  logic [CW-1:0] max_arr;
  logic skew_bad;

  logic [DATA_WIDTH-1:0] dl [NUM_LANES][DEPTH];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign pat_hit[g] =
      data_in[g*DATA_WIDTH +: DATA_WIDTH] == pattern;
    assign sync_hit[g] =
      data_in[g*DATA_WIDTH +: DATA_WIDTH] == sync_word;
    assign bitslip[g]     = l_st[g] == L_SLIP;
    assign lane_locked[g] = l_st[g] == L_LOCK;
    assign lane_fail[g]   = l_st[g] == L_FAIL;
`ifdef ALIGN_STATS_EN
    assign slip_count[g*4 +: 4] = slip_cnt[g];
    assign lane_skew[g*5 +: 5]  = 5'(delay[g]);
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      l_nxt[i]     = l_st[i];
      slip_nxt[i]  = slip_cnt[i];
      match_nxt[i] = match_cnt[i];
      wait_nxt[i]  = wait_cnt[i];
      unique case (l_st[i])
        L_IDLE: if (lane_ready[i]) begin
          l_nxt[i]     = L_CHECK;
          slip_nxt[i]  = '0;
          match_nxt[i] = '0;
        end
        L_CHECK: if (pat_hit[i]) begin
          match_nxt[i] = match_cnt[i] + 1'b1;
          if (match_cnt[i] == MC_LAST) l_nxt[i] = L_LOCK;
        end else begin
          match_nxt[i] = '0;
          l_nxt[i] = (slip_cnt[i] < SLIP_MAX) ? L_SLIP : L_FAIL;
        end
        L_SLIP: begin
          slip_nxt[i] = slip_cnt[i] + 1'b1;
          wait_nxt[i] = '0;
          l_nxt[i]    = L_WAIT;
        end
        L_WAIT: if (wait_cnt[i] == SW_LAST) l_nxt[i] = L_CHECK;
                else wait_nxt[i] = wait_cnt[i] + 1'b1;
        L_LOCK, L_FAIL: begin end
        default: l_nxt[i] = L_IDLE;
      endcase
      // losing tap alignment only aborts a lane that is still searching
      if (!lane_ready[i] && (l_st[i] == L_CHECK ||
          l_st[i] == L_SLIP || l_st[i] == L_WAIT))
        l_nxt[i] = L_IDLE;
      if (!align_en) begin
        l_nxt[i]     = L_IDLE;
        slip_nxt[i]  = '0;
        match_nxt[i] = '0;
        wait_nxt[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!reset) begin
        l_st[i]      <= L_IDLE;
        slip_cnt[i]  <= '0;
        match_cnt[i] <= '0;
        wait_cnt[i]  <= '0;
      end else begin
        l_st[i]      <= l_nxt[i];
        slip_cnt[i]  <= slip_nxt[i];
        match_cnt[i] <= match_nxt[i];
        wait_cnt[i]  <= wait_nxt[i];
      end
    end
  end

  always_comb begin
    max_arr  = '0;
    skew_bad = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (arrival[i] > max_arr) max_arr = arrival[i];
    for (int i = 0; i < NUM_LANES; i++)
      if (max_arr - arrival[i] > SKEW_LIM) skew_bad = 1'b1;
    d_nxt = d_st;
    unique case (d_st)
      D_IDLE: if (&lane_locked) d_nxt = D_SEARCH;
      D_SEARCH: if (&cap) d_nxt = skew_bad ? D_FAIL : D_DONE;
                else if (cnt == TO_CNT) d_nxt = D_FAIL;
      D_DONE, D_FAIL: d_nxt = d_st;
    endcase
    if (!align_en) d_nxt = D_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_st <= D_IDLE;
      cnt  <= '0;
      cap  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        arrival[i] <= '0;
        delay[i]   <= '0;
      end
    end else begin
      d_st <= d_nxt;
      if (!align_en || d_st == D_IDLE) begin
        cnt <= '0;
        cap <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          arrival[i] <= '0;
          delay[i]   <= '0;
        end
      end else if (d_st == D_SEARCH) begin
        cnt <= cnt + 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (!cap[i] && sync_hit[i]) begin
            cap[i]     <= 1'b1;
            arrival[i] <= cnt;
          end
          if (&cap) delay[i] <= DLW'(max_arr - arrival[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!reset) begin
        for (int k = 0; k < DEPTH; k++) dl[i][k] <= '0;
      end else begin
        dl[i][0] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k < DEPTH; k++) dl[i][k] <= dl[i][k-1];
      end
    end
  end

  always_comb begin
    tdata = '0;
    for (int i = 0; i < NUM_LANES; i++)
      for (int k = 0; k < DEPTH; k++)
        if (delay[i] == DLW'(k))
          tdata[i*DATA_WIDTH +: DATA_WIDTH] = dl[i][k];
  end

  assign align_done = d_st == D_DONE;
  assign tvalid     = d_st == D_DONE;
  assign align_fail = (|lane_fail) || (d_st == D_FAIL);

endmodule
